// File: rtl/sort_serializer.sv
// Serializes the sorted vector from the last bitonic merge stage onto a valid/ready stream.
// Each captured vector becomes one frame. The block counts completed frames and flags vectors it had to drop.
module sort_serializer #(
  parameter int width       = 8,
  parameter int index       = 8,
  parameter int index_width = 3,
  parameter bit descend     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data [0:index-1],
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [15:0]      frame_count,
  output logic             overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [index_width-1:0] LAST = index_width'(index - 1);

  state_t                 state_q, state_d;
  logic [index_width-1:0] beat_q, beat_d;
  logic [width-1:0]       buf_q [0:index-1];
  logic [width-1:0]       buf_d [0:index-1];
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   overrun_q, overrun_d;

  logic beat_fire;
  logic at_last;
  logic capture;

  assign at_last   = (beat_q == LAST);
  assign beat_fire = (state_q == SEND) && out_ready;
  assign in_ready  = (state_q == IDLE) || (beat_fire && at_last);
  assign capture   = in_valid && in_ready;

  // Outputs are decoded from registers only; in_* never reaches out_* combinationally.
  assign out_valid   = (state_q == SEND);
  assign out_last    = (state_q == SEND) && at_last;
  assign out_data    = descend ? buf_q[LAST - beat_q] : buf_q[beat_q];
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    buf_d         = buf_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;

    if (beat_fire) begin
      if (at_last) begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = IDLE;
      end else begin
        beat_d = beat_q + index_width'(1);
      end
    end

    // A capture on the last accepted beat overrides the return to IDLE, so frames run back to back.
    if (capture) begin
      buf_d   = in_data;
      beat_d  = '0;
      state_d = SEND;
    end

    if (in_valid && !in_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < index; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      buf_q         <= buf_d;
    end
  end

endmodule

// File: tb/tb_sort_serializer.sv
// Directed testbench for sort_serializer: one ascending and one descending instance share all inputs.
module tb_sort_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data [0:7];
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_last_a, overrun_a;
  logic [7:0] out_data_a;
  logic [15:0] frame_count_a;
  logic       in_ready_d, out_valid_d, out_last_d, overrun_d;
  logic [7:0] out_data_d;
  logic [15:0] frame_count_d;

  logic [7:0] vec_a [0:7];
  logic [7:0] vec_b [0:7];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sort_serializer #(.width(8), .index(8), .index_width(3), .descend(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_last(out_last_a), .frame_count(frame_count_a), .overrun(overrun_a)
  );

  sort_serializer #(.width(8), .index(8), .index_width(3), .descend(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_d),
    .out_data(out_data_d), .out_valid(out_valid_d), .out_ready(out_ready),
    .out_last(out_last_d), .frame_count(frame_count_d), .overrun(overrun_d)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic capture_a();
    in_data = vec_a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (out_valid_a !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid_a); end
    tests++;
    if (out_last_a !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", out_last_a); end
    tests++;
    if (frame_count_a !== 16'd0) begin fails++; $display("FAIL reset_frame_count got %0d want 0", frame_count_a); end
    tests++;
    if (overrun_a !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun_a); end
    tests++;
    if (in_ready_a !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready_a); end
    tests++;
    if (out_valid_d !== 1'b0) begin fails++; $display("FAIL reset_out_valid_desc got %b want 0", out_valid_d); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_frame();
    logic [7:0] exp [0:7];
    exp = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd20, 8'd33, 8'd40, 8'd255};
    do_reset();
    capture_a();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (out_valid_a !== 1'b1) begin fails++; $display("FAIL single_valid beat %0d got %b want 1", i, out_valid_a); end
      tests++;
      if (out_data_a !== exp[i]) begin fails++; $display("FAIL single_data beat %0d got %0d want %0d", i, out_data_a, exp[i]); end
      tests++;
      if (out_last_a !== (i == 7)) begin fails++; $display("FAIL single_last beat %0d got %b want %b", i, out_last_a, (i == 7)); end
      step();
    end
    tests++;
    if (out_valid_a !== 1'b0) begin fails++; $display("FAIL single_idle_valid got %b want 0", out_valid_a); end
    tests++;
    if (frame_count_a !== 16'd1) begin fails++; $display("FAIL single_frame_count got %0d want 1", frame_count_a); end
    tests++;
    if (in_ready_a !== 1'b1) begin fails++; $display("FAIL single_in_ready got %b want 1", in_ready_a); end
    $display("[TB] test_single_frame done");
  endtask

  task automatic test_descend();
    logic [7:0] exp [0:7];
    exp = '{8'd255, 8'd40, 8'd33, 8'd20, 8'd12, 8'd9, 8'd7, 8'd3};
    do_reset();
    capture_a();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (out_data_d !== exp[i]) begin fails++; $display("FAIL desc_data beat %0d got %0d want %0d", i, out_data_d, exp[i]); end
      tests++;
      if (out_last_d !== (i == 7)) begin fails++; $display("FAIL desc_last beat %0d got %b want %b", i, out_last_d, (i == 7)); end
      step();
    end
    tests++;
    if (frame_count_d !== 16'd1) begin fails++; $display("FAIL desc_frame_count got %0d want 1", frame_count_d); end
    $display("[TB] test_descend done");
  endtask

  task automatic test_backpressure();
    logic pat [0:3];
    int accepted;
    int cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    accepted = 0;
    cyc = 0;
    do_reset();
    capture_a();
    while (accepted < 8 && cyc < 40) begin
      out_ready = pat[cyc % 4];
      tests++;
      if (out_valid_a !== 1'b1) begin fails++; $display("FAIL bp_valid cycle %0d got %b want 1", cyc, out_valid_a); end
      tests++;
      if (out_data_a !== vec_a[accepted]) begin fails++; $display("FAIL bp_data cycle %0d got %0d want %0d", cyc, out_data_a, vec_a[accepted]); end
      tests++;
      if (out_last_a !== (accepted == 7)) begin fails++; $display("FAIL bp_last cycle %0d got %b want %b", cyc, out_last_a, (accepted == 7)); end
      if (out_ready) accepted++;
      step();
      cyc++;
    end
    out_ready = 1'b1;
    tests++;
    if (accepted != 8) begin fails++; $display("FAIL bp_timeout accepted %0d want 8", accepted); end
    tests++;
    if (out_valid_a !== 1'b0) begin fails++; $display("FAIL bp_idle_valid got %b want 0", out_valid_a); end
    tests++;
    if (frame_count_a !== 16'd1) begin fails++; $display("FAIL bp_frame_count got %0d want 1", frame_count_a); end
    $display("[TB] test_backpressure done, %0d cycles", cyc);
  endtask

  task automatic test_back_to_back();
    do_reset();
    capture_a();
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        in_data = vec_b;
        in_valid = 1'b1;
        tests++;
        if (in_ready_a !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %b want 1", in_ready_a); end
      end
      tests++;
      if (out_valid_a !== 1'b1) begin fails++; $display("FAIL b2b_valid beat %0d got %b want 1", i, out_valid_a); end
      tests++;
      if (out_data_a !== ((i < 8) ? vec_a[i] : vec_b[i-8])) begin
        fails++; $display("FAIL b2b_data beat %0d got %0d want %0d", i, out_data_a, (i < 8) ? vec_a[i] : vec_b[i-8]);
      end
      step();
      in_valid = 1'b0;
    end
    tests++;
    if (out_valid_a !== 1'b0) begin fails++; $display("FAIL b2b_idle_valid got %b want 0", out_valid_a); end
    tests++;
    if (frame_count_a !== 16'd2) begin fails++; $display("FAIL b2b_frame_count got %0d want 2", frame_count_a); end
    tests++;
    if (overrun_a !== 1'b0) begin fails++; $display("FAIL b2b_overrun got %b want 0", overrun_a); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_overrun();
    do_reset();
    capture_a();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        in_data = vec_b;
        in_valid = 1'b1;
        tests++;
        if (in_ready_a !== 1'b0) begin fails++; $display("FAIL ovr_in_ready got %b want 0", in_ready_a); end
      end
      tests++;
      if (out_data_a !== vec_a[i]) begin fails++; $display("FAIL ovr_data beat %0d got %0d want %0d", i, out_data_a, vec_a[i]); end
      step();
      in_valid = 1'b0;
    end
    tests++;
    if (overrun_a !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", overrun_a); end
    tests++;
    if (frame_count_a !== 16'd1) begin fails++; $display("FAIL ovr_frame_count got %0d want 1", frame_count_a); end
    step();
    step();
    tests++;
    if (overrun_a !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b want 1", overrun_a); end
    $display("[TB] test_overrun done");
  endtask

  // Starts with overrun=1 and frame_count=1 left by test_overrun, so the reset has something to clear.
  task automatic test_reset_mid_frame();
    capture_a();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (out_valid_a !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", out_valid_a); end
    tests++;
    if (frame_count_a !== 16'd0) begin fails++; $display("FAIL mid_frame_count got %0d want 0", frame_count_a); end
    tests++;
    if (overrun_a !== 1'b0) begin fails++; $display("FAIL mid_overrun got %b want 0", overrun_a); end
    tests++;
    if (in_ready_a !== 1'b1) begin fails++; $display("FAIL mid_in_ready got %b want 1", in_ready_a); end
    in_data = vec_b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (out_data_a !== vec_b[i]) begin fails++; $display("FAIL mid_new_data beat %0d got %0d want %0d", i, out_data_a, vec_b[i]); end
      step();
    end
    tests++;
    if (frame_count_a !== 16'd1) begin fails++; $display("FAIL mid_new_frame_count got %0d want 1", frame_count_a); end
    $display("[TB] test_reset_mid_frame done");
  endtask

  initial begin
    vec_a = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd20, 8'd33, 8'd40, 8'd255};
    vec_b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    in_data = vec_a;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_single_frame();
    test_descend();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
